// File: rtl/dual_port_ssram_pkg.sv
// rtl/dual_port_ssram_pkg.sv - shared constants, FSM state type and byte merge helper
// Contents:
//   READ_OLD / READ_NEW : same-port read-during-write selections
//   state_t             : controller state (IDLE serves ports, CLEAR runs the fill)
//   merge_byte          : picks the new or old byte of a word lane
package dual_port_ssram_pkg;

    localparam int READ_OLD = 0;
    localparam int READ_NEW = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       take_new
    );
        return take_new ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/dual_port_byte_ram.sv
// rtl/dual_port_byte_ram.sv - byte-laned true dual-port array, read-first, no reset
// Ports (per port x = a/b):
//   clk    : clock, both ports synchronous to its rising edge
//   en_x   : read enable; q_x updates only when set
//   we_x   : write enable, qualified per byte by be_x
//   be_x   : byte write mask
//   addr_x : word address
//   din_x  : write data
//   q_x    : registered read data (contents before any write in the same cycle)
module dual_port_byte_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    en_a,
    input  logic                    we_a,
    input  logic [DATA_WIDTH/8-1:0] be_a,
    input  logic [ADDR_WIDTH-1:0]   addr_a,
    input  logic [DATA_WIDTH-1:0]   din_a,
    output logic [DATA_WIDTH-1:0]   q_a,
    input  logic                    en_b,
    input  logic                    we_b,
    input  logic [DATA_WIDTH/8-1:0] be_b,
    input  logic [ADDR_WIDTH-1:0]   addr_b,
    input  logic [DATA_WIDTH-1:0]   din_b,
    output logic [DATA_WIDTH-1:0]   q_b
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reads use the pre-edge contents, so both ports see old data when the
    // same address is written in the same cycle. The controller guarantees
    // the two ports never write the same byte together.
    always_ff @(posedge clk) begin
        if (en_a) q_a <= mem[addr_a];
        if (en_b) q_b <= mem[addr_b];
        for (int i = 0; i < BYTES; i++) begin
            if (we_a && be_a[i]) mem[addr_a][i*8 +: 8] <= din_a[i*8 +: 8];
            if (we_b && be_b[i]) mem[addr_b][i*8 +: 8] <= din_b[i*8 +: 8];
        end
    end

endmodule

// File: rtl/dual_port_ssram_ctrl.sv
// rtl/dual_port_ssram_ctrl.sv - dual-port SRAM controller with clear sequencer and collision detect
// Ports:
//   clock, nReset           : clock and asynchronous active-low reset
//   startClear, busy        : clear request and clear-in-progress flag
//   collision               : pulse when both ports write the same address together
//   enableX, writeEnableX   : port X access request and write qualifier (X = A/B)
//   byteEnableX             : port X byte write mask
//   addressX, dataInX       : port X word address and write data
//   dataOutX, validX        : port X read data and its one-cycle valid strobe
module dual_port_ssram_ctrl
    import dual_port_ssram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 9,
    parameter int                    READ_MODE      = 0,
    parameter int                    OUTPUT_REG     = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                    clock,
    input  logic                    nReset,
    input  logic                    startClear,
    output logic                    busy,
    output logic                    collision,
    input  logic                    enableA,
    input  logic                    writeEnableA,
    input  logic [DATA_WIDTH/8-1:0] byteEnableA,
    input  logic [ADDR_WIDTH-1:0]   addressA,
    input  logic [DATA_WIDTH-1:0]   dataInA,
    output logic [DATA_WIDTH-1:0]   dataOutA,
    output logic                    validA,
    input  logic                    enableB,
    input  logic                    writeEnableB,
    input  logic [DATA_WIDTH/8-1:0] byteEnableB,
    input  logic [ADDR_WIDTH-1:0]   addressB,
    input  logic [DATA_WIDTH-1:0]   dataInB,
    output logic [DATA_WIDTH-1:0]   dataOutB,
    output logic                    validB
);

    localparam int                    BYTES     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clear_count;
    logic                    clear_we;
    logic                    port_open;

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (startClear) state_next = CLEAR;
            CLEAR:   if (clear_count == LAST_ADDR) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == CLEAR);
        clear_we  = (state == CLEAR);
        port_open = (state == IDLE);
    end

    // Held at zero outside CLEAR so every clear starts from address 0.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset)             clear_count <= '0;
        else if (state == CLEAR) clear_count <= clear_count + ADDR_WIDTH'(1);
        else                     clear_count <= '0;
    end

    // ---------------- request qualification ----------------
    logic             acc_a, acc_b, wr_a, wr_b, dual_same;
    logic [BYTES-1:0] be_b_eff;

    assign acc_a     = enableA & port_open;
    assign acc_b     = enableB & port_open;
    // An all-zero byte mask writes nothing, so it is treated as a plain read.
    assign wr_a      = acc_a & writeEnableA & (|byteEnableA);
    assign wr_b      = acc_b & writeEnableB & (|byteEnableB);
    assign dual_same = wr_a & wr_b & (addressA == addressB);
    // Port A owns every byte it enables on a same-address dual write.
    assign be_b_eff  = dual_same ? (byteEnableB & ~byteEnableA) : byteEnableB;

    // The clear sequencer borrows port A of the array; ports are closed then.
    logic [ADDR_WIDTH-1:0] ram_addr_a;
    logic [DATA_WIDTH-1:0] ram_din_a, ram_q_a, ram_q_b;
    logic [BYTES-1:0]      ram_be_a;
    logic                  ram_we_a;

    assign ram_we_a   = clear_we | wr_a;
    assign ram_be_a   = clear_we ? '1 : byteEnableA;
    assign ram_addr_a = clear_we ? clear_count : addressA;
    assign ram_din_a  = clear_we ? CLEAR_VALUE : dataInA;

    dual_port_byte_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clock),
        .en_a  (acc_a),
        .we_a  (ram_we_a),
        .be_a  (ram_be_a),
        .addr_a(ram_addr_a),
        .din_a (ram_din_a),
        .q_a   (ram_q_a),
        .en_b  (acc_b),
        .we_b  (wr_b),
        .be_b  (be_b_eff),
        .addr_b(addressB),
        .din_b (dataInB),
        .q_b   (ram_q_b)
    );

    // ---------------- read pipeline ----------------
    // Stage 1 runs alongside the array read. The mask stays zero unless the
    // port wrote in write-through mode, so the merge then returns old data.
    logic                  valid1_a, valid1_b, coll1;
    logic [DATA_WIDTH-1:0] wdata1_a, wdata1_b;
    logic [BYTES-1:0]      mask1_a, mask1_b;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            valid1_a <= 1'b0;
            valid1_b <= 1'b0;
            coll1    <= 1'b0;
            wdata1_a <= '0;
            wdata1_b <= '0;
            mask1_a  <= '0;
            mask1_b  <= '0;
        end else begin
            valid1_a <= acc_a;
            valid1_b <= acc_b;
            coll1    <= dual_same;
            if (acc_a) begin
                wdata1_a <= dataInA;
                mask1_a  <= (READ_MODE == READ_NEW && wr_a) ? byteEnableA : '0;
            end
            if (acc_b) begin
                wdata1_b <= dataInB;
                mask1_b  <= (READ_MODE == READ_NEW && wr_b) ? byteEnableB : '0;
            end
        end
    end

    logic [DATA_WIDTH-1:0] merged_a, merged_b;

    always_comb begin
        merged_a = '0;
        merged_b = '0;
        for (int i = 0; i < BYTES; i++) begin
            merged_a[i*8 +: 8] = merge_byte(ram_q_a[i*8 +: 8], wdata1_a[i*8 +: 8], mask1_a[i]);
            merged_b[i*8 +: 8] = merge_byte(ram_q_b[i*8 +: 8], wdata1_b[i*8 +: 8], mask1_b[i]);
        end
    end

    // data_r_x doubles as the hold register (no output register) and as the
    // pipeline register (output register); either way it carries the last
    // completed read and is zero after reset.
    logic [DATA_WIDTH-1:0] stage_a, stage_b, data_r_a, data_r_b;
    logic                  valid_r_a, valid_r_b, coll_r;

    assign stage_a = valid1_a ? merged_a : data_r_a;
    assign stage_b = valid1_b ? merged_b : data_r_b;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            data_r_a  <= '0;
            data_r_b  <= '0;
            valid_r_a <= 1'b0;
            valid_r_b <= 1'b0;
            coll_r    <= 1'b0;
        end else begin
            data_r_a  <= stage_a;
            data_r_b  <= stage_b;
            valid_r_a <= valid1_a;
            valid_r_b <= valid1_b;
            coll_r    <= coll1;
        end
    end

    assign dataOutA  = (OUTPUT_REG != 0) ? data_r_a  : stage_a;
    assign dataOutB  = (OUTPUT_REG != 0) ? data_r_b  : stage_b;
    assign validA    = (OUTPUT_REG != 0) ? valid_r_a : valid1_a;
    assign validB    = (OUTPUT_REG != 0) ? valid_r_b : valid1_b;
    assign collision = (OUTPUT_REG != 0) ? coll_r    : coll1;

endmodule

// File: tb/tb_dual_port_ssram_ctrl.sv
// tb/tb_dual_port_ssram_ctrl.sv - directed scoreboard bench for dual_port_ssram_ctrl
module tb_dual_port_ssram_ctrl;

    localparam logic [31:0] CLR = 32'hDEADBEEF;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        n_reset = 1'b0;
    logic        start_clear = 1'b0;
    logic        enable_a = 1'b0, write_enable_a = 1'b0;
    logic [3:0]  byte_enable_a = '0, address_a = '0;
    logic [31:0] data_in_a = '0;
    logic        enable_b = 1'b0, write_enable_b = 1'b0;
    logic [3:0]  byte_enable_b = '0, address_b = '0;
    logic [31:0] data_in_b = '0;

    logic        busy0, busy1, collision0, collision1;
    logic        valid_a0, valid_b0, valid_a1, valid_b1;
    logic [31:0] data_out_a0, data_out_b0, data_out_a1, data_out_b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int coll_cnt0 = 0;
    int coll_cnt1 = 0;

    logic [31:0] mem_m [16];
    exp_t        exp_q [4][$];
    exp_t        mon_e;
    string       names [4] = '{"A0", "B0", "A1", "B1"};
    logic [3:0]  vld;
    logic [31:0] dout [4];

    assign vld     = {valid_b1, valid_a1, valid_b0, valid_a0};
    assign dout[0] = data_out_a0;
    assign dout[1] = data_out_b0;
    assign dout[2] = data_out_a1;
    assign dout[3] = data_out_b1;

    // dut0: read-first, no output register; dut1: write-through, output register
    dual_port_ssram_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_MODE(0), .OUTPUT_REG(0),
        .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)
    ) dut0 (
        .clock(clock), .nReset(n_reset), .startClear(start_clear),
        .busy(busy0), .collision(collision0),
        .enableA(enable_a), .writeEnableA(write_enable_a), .byteEnableA(byte_enable_a),
        .addressA(address_a), .dataInA(data_in_a), .dataOutA(data_out_a0), .validA(valid_a0),
        .enableB(enable_b), .writeEnableB(write_enable_b), .byteEnableB(byte_enable_b),
        .addressB(address_b), .dataInB(data_in_b), .dataOutB(data_out_b0), .validB(valid_b0)
    );

    dual_port_ssram_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_MODE(1), .OUTPUT_REG(1),
        .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)
    ) dut1 (
        .clock(clock), .nReset(n_reset), .startClear(start_clear),
        .busy(busy1), .collision(collision1),
        .enableA(enable_a), .writeEnableA(write_enable_a), .byteEnableA(byte_enable_a),
        .addressA(address_a), .dataInA(data_in_a), .dataOutA(data_out_a1), .validA(valid_a1),
        .enableB(enable_b), .writeEnableB(write_enable_b), .byteEnableB(byte_enable_b),
        .addressB(address_b), .dataInB(data_in_b), .dataOutB(data_out_b1), .validB(valid_b1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clock) begin
        if (collision0 === 1'b1) coll_cnt0 <= coll_cnt0 + 1;
        if (collision1 === 1'b1) coll_cnt1 <= coll_cnt1 + 1;
        for (int p = 0; p < 4; p++) begin
            if (vld[p] === 1'b1) begin
                chk({names[p], "_valid_expected"}, 32'(exp_q[p].size() != 0), 32'd1);
                if (exp_q[p].size() != 0) begin
                    mon_e = exp_q[p].pop_front();
                    chk({names[p], "_data"}, dout[p], mon_e.data);
                    chk({names[p], "_latency"}, cyc, mon_e.due);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    // Drives one request cycle; the model predicts both DUTs' read results.
    task automatic access(input logic ea, input logic wa, input logic [3:0] bea,
                          input logic [3:0] aa, input logic [31:0] da,
                          input logic eb, input logic wb, input logic [3:0] beb,
                          input logic [3:0] ab, input logic [31:0] db, input logic sc);
        logic [31:0] old_a, old_b, mrg_a, mrg_b;
        logic        wr_a, wr_b;
        logic [3:0]  eff_b;
        old_a = mem_m[aa];
        old_b = mem_m[ab];
        wr_a  = ea && wa && (bea != 4'd0);
        wr_b  = eb && wb && (beb != 4'd0);
        mrg_a = old_a;
        mrg_b = old_b;
        for (int i = 0; i < 4; i++) begin
            if (wr_a && bea[i]) mrg_a[i*8 +: 8] = da[i*8 +: 8];
            if (wr_b && beb[i]) mrg_b[i*8 +: 8] = db[i*8 +: 8];
        end
        eff_b = (wr_a && wr_b && aa == ab) ? (beb & ~bea) : beb;
        if (ea) begin
            exp_q[0].push_back('{old_a, cyc + 1});
            exp_q[2].push_back('{mrg_a, cyc + 2});
        end
        if (eb) begin
            exp_q[1].push_back('{old_b, cyc + 1});
            exp_q[3].push_back('{mrg_b, cyc + 2});
        end
        for (int i = 0; i < 4; i++) begin
            if (wr_a && bea[i])   mem_m[aa][i*8 +: 8] = da[i*8 +: 8];
            if (wr_b && eff_b[i]) mem_m[ab][i*8 +: 8] = db[i*8 +: 8];
        end
        if (sc) for (int i = 0; i < 16; i++) mem_m[i] = CLR;
        enable_a = ea; write_enable_a = wa; byte_enable_a = bea; address_a = aa; data_in_a = da;
        enable_b = eb; write_enable_b = wb; byte_enable_b = beb; address_b = ab; data_in_b = db;
        start_clear = sc;
        sync();
        enable_a = 1'b0; write_enable_a = 1'b0; byte_enable_a = '0;
        enable_b = 1'b0; write_enable_b = 1'b0; byte_enable_b = '0;
        start_clear = 1'b0;
    endtask

    task automatic chk_reset_state();
        for (int p = 0; p < 4; p++) begin
            chk({names[p], "_reset_data"}, dout[p], 32'd0);
            chk({names[p], "_reset_valid"}, 32'(vld[p]), 32'd0);
        end
        chk("reset_collision0", 32'(collision0), 32'd0);
        chk("reset_collision1", 32'(collision1), 32'd0);
        chk("reset_busy0", 32'(busy0), 32'd1);
        chk("reset_busy1", 32'(busy1), 32'd1);
    endtask

    // Counts busy cycles after reset release; optionally holds ignored
    // port requests for the first 10 busy cycles.
    task automatic count_busy(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (busy0 !== 1'b1) break;
            n++;
            if (n == 10) begin
                enable_a = 1'b0; enable_b = 1'b0; write_enable_b = 1'b0; byte_enable_b = '0;
            end
        end
        chk(tag, n, 32'd16);
        chk({tag, "_dut1"}, 32'(busy1), 32'd0);
        sync();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_m[i] = CLR;

        // reset and clear-on-reset
        @(negedge clock);
        @(negedge clock);
        chk_reset_state();
        sync();
        n_reset = 1'b1;
        count_busy("busy_after_reset");

        // read the whole cleared array, B reading in reverse alongside
        for (int i = 0; i < 16; i++)
            access(1, 0, 4'h0, 4'(i), '0, 1, 0, 4'h0, 4'(15 - i), '0, 0);

        // byte writes
        access(1, 1, 4'hF, 4'd5, 32'h11223344, 0, 0, 4'h0, 4'd0, '0, 0);
        access(1, 1, 4'h5, 4'd5, 32'hAABBCCDD, 0, 0, 4'h0, 4'd0, '0, 0);
        access(0, 0, 4'h0, 4'd0, '0, 1, 0, 4'h0, 4'd5, '0, 0);

        // read-during-write, same port and cross port
        access(1, 1, 4'hF, 4'd3, 32'h0, 0, 0, 4'h0, 4'd0, '0, 0);
        access(1, 1, 4'hF, 4'd3, 32'hCAFE0001, 1, 0, 4'h0, 4'd3, '0, 0);

        // same-address dual write
        access(1, 1, 4'h3, 4'd7, 32'hAAAAAAAA, 1, 1, 4'hF, 4'd7, 32'hBBBBBBBB, 0);
        @(negedge clock);
        chk("collision0_pulse", 32'(collision0), 32'd1);
        chk("collision1_early", 32'(collision1), 32'd0);
        @(negedge clock);
        chk("collision0_end", 32'(collision0), 32'd0);
        chk("collision1_pulse", 32'(collision1), 32'd1);
        sync();
        access(1, 0, 4'h0, 4'd7, '0, 1, 0, 4'h0, 4'd7, '0, 0);
        // different addresses: no collision
        access(1, 1, 4'hF, 4'd10, 32'h01020304, 1, 1, 4'hF, 4'd11, 32'h05060708, 0);
        access(1, 0, 4'h0, 4'd10, '0, 1, 0, 4'h0, 4'd11, '0, 0);

        // back-to-back reads for pipeline latency, then hold
        access(1, 0, 4'h0, 4'd1, '0, 0, 0, 4'h0, 4'd0, '0, 0);
        access(1, 0, 4'h0, 4'd2, '0, 0, 0, 4'h0, 4'd0, '0, 0);
        access(1, 0, 4'h0, 4'd3, '0, 0, 0, 4'h0, 4'd0, '0, 0);
        repeat (3) @(negedge clock);
        chk("holdA0_data", data_out_a0, mem_m[3]);
        chk("holdA1_data", data_out_a1, mem_m[3]);
        chk("holdA0_valid", 32'(valid_a0), 32'd0);
        sync();

        // write with empty mask behaves as a read
        access(1, 1, 4'h0, 4'd4, 32'h99999999, 0, 0, 4'h0, 4'd0, '0, 0);
        access(0, 0, 4'h0, 4'd0, '0, 1, 0, 4'h0, 4'd4, '0, 0);

        // startClear alongside a write, then reset mid-clear
        access(1, 1, 4'hF, 4'd9, 32'h12345678, 0, 0, 4'h0, 4'd0, '0, 1);
        repeat (5) sync();
        n_reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk_reset_state();
        sync();
        n_reset = 1'b1;
        enable_a = 1'b1; address_a = 4'd2;
        enable_b = 1'b1; write_enable_b = 1'b1; byte_enable_b = 4'hF;
        address_b = 4'd2; data_in_b = 32'h55555555;
        count_busy("busy_after_midclear_reset");

        access(1, 0, 4'h0, 4'd2, '0, 1, 0, 4'h0, 4'd9, '0, 0);
        access(1, 0, 4'h0, 4'd5, '0, 1, 0, 4'h0, 4'd7, '0, 0);
        repeat (4) sync();

        for (int p = 0; p < 4; p++)
            chk({names[p], "_queue_drained"}, exp_q[p].size(), 32'd0);
        chk("collision0_count", coll_cnt0, 32'd1);
        chk("collision1_count", coll_cnt1, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
